// File: rtl/neuron_layer_sched.sv
// Time-multiplexed scheduler that runs N_NEURONS 2-input Q-format neurons (ReLU) over one input pair on a shared MAC.
// Optional macro NEURON_SAT_EN: saturate the shifted sum to W bits instead of wrapping it.
module neuron_layer_sched #(
  parameter int INT_BITS  = 6,
  parameter int FRAC_BITS = 12,
  parameter int N_NEURONS = 4,
  localparam int W        = INT_BITS + FRAC_BITS,
  localparam int IDX_W    = $clog2(N_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x1,
  input  logic [W-1:0]     in_x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [W-1:0]     cfg_data,
  output logic             cfg_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // out_y/out_idx/out_last stay stable while out_valid is high and out_ready is low.

  localparam int ACC_W = 2 * W + 2;
  localparam int T_W   = ACC_W - FRAC_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [IDX_W:0]   N_LIMIT  = (IDX_W + 1)'(N_NEURONS);
  localparam logic [W-1:0]     Y_MAX    = {1'b0, {(W - 1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC1 = 2'd1,
    S_MAC2 = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                  r_state;
  logic signed [W-1:0]     r_w1   [N_NEURONS];
  logic signed [W-1:0]     r_w2   [N_NEURONS];
  logic signed [W-1:0]     r_bias [N_NEURONS];
  logic signed [W-1:0]     r_x1;
  logic signed [W-1:0]     r_x2;
  logic [IDX_W-1:0]        r_idx;
  logic signed [ACC_W-1:0] r_acc;
  logic [W-1:0]            r_out_y;
  logic [IDX_W-1:0]        r_out_idx;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic                    r_cfg_err;

  logic signed [W-1:0]     w_w1;
  logic signed [W-1:0]     w_w2;
  logic signed [W-1:0]     w_bias;
  logic signed [2*W-1:0]   w_prod1;
  logic signed [2*W-1:0]   w_prod2;
  logic signed [ACC_W-1:0] w_bias_sh;
  logic signed [ACC_W-1:0] w_mac1;
  logic signed [ACC_W-1:0] w_sum;
  logic [T_W-1:0]          w_t;
  logic [W-1:0]            w_y;
  logic                    w_cfg_idx_ok;
  logic                    w_accept;
  logic                    w_unused;

  assign w_w1   = r_w1[r_idx];
  assign w_w2   = r_w2[r_idx];
  assign w_bias = r_bias[r_idx];

  assign w_prod1   = r_x1 * w_w1;
  assign w_prod2   = r_x2 * w_w2;
  assign w_bias_sh = {{(ACC_W - W - FRAC_BITS){w_bias[W-1]}}, w_bias, {FRAC_BITS{1'b0}}};
  assign w_mac1    = w_bias_sh + {{2{w_prod1[2*W-1]}}, w_prod1};
  assign w_sum     = r_acc + {{2{w_prod2[2*W-1]}}, w_prod2};
  // Dropping the low FRAC_BITS of a signed value is an arithmetic shift rounding toward -inf.
  assign w_t       = w_sum[ACC_W-1:FRAC_BITS];

`ifdef NEURON_SAT_EN
  always_comb begin
    w_y = '0;
    if (w_t[T_W-1]) begin
      w_y = '0;
    end else if (|w_t[T_W-2:W-1]) begin
      w_y = Y_MAX;
    end else begin
      w_y = w_t[W-1:0];
    end
  end
  assign w_unused = ^w_sum[FRAC_BITS-1:0];
`else
  always_comb begin
    w_y = '0;
    if (!w_t[W-1]) begin
      w_y = w_t[W-1:0];
    end
  end
  assign w_unused = ^{w_sum[FRAC_BITS-1:0], w_t[T_W-1:W]};
`endif

  assign w_cfg_idx_ok = ({1'b0, cfg_idx} < N_LIMIT);
  assign w_accept     = in_valid && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x1        <= '0;
      r_x2        <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_y     <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_cfg_err   <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_w1[i]   <= '0;
        r_w2[i]   <= '0;
        r_bias[i] <= '0;
      end
    end else begin
      r_cfg_err <= 1'b0;
      // Writes land at the same edge as an accept, so the pass sees the new value in MAC1.
      if (cfg_we) begin
        if ((r_state == S_IDLE) && w_cfg_idx_ok) begin
          case (cfg_sel)
            2'd0:    r_w1[cfg_idx]   <= cfg_data;
            2'd1:    r_w2[cfg_idx]   <= cfg_data;
            2'd2:    r_bias[cfg_idx] <= cfg_data;
            default: ;
          endcase
        end else begin
          r_cfg_err <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x1    <= in_x1;
            r_x2    <= in_x2;
            r_idx   <= '0;
            r_state <= S_MAC1;
          end
        end
        S_MAC1: begin
          r_acc   <= w_mac1;
          r_state <= S_MAC2;
        end
        S_MAC2: begin
          r_out_y     <= w_y;
          r_out_idx   <= r_idx;
          r_out_last  <= (r_idx == LAST_IDX);
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_MAC1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign cfg_err   = r_cfg_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Bench for neuron_layer_sched: directed and random pairs checked against an integer-arithmetic neuron model.
// Define NEURON_SAT_EN for both bench and RTL to check the saturating build.
module tb_neuron_layer_sched;

  localparam int INT_BITS  = 6;
  localparam int FRAC_BITS = 12;
  localparam int N         = 4;
  localparam int W         = INT_BITS + FRAC_BITS;
  localparam int IDX_W     = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 0, in_ready, out_valid, out_ready = 0, out_last;
  logic [W-1:0]     in_x1 = '0, in_x2 = '0, out_y, cfg_data = '0;
  logic [IDX_W-1:0] out_idx, cfg_idx = '0;
  logic             cfg_we = 0, cfg_err, busy;
  logic [1:0]       cfg_sel = '0, dbg_state;

  neuron_layer_sched #(.INT_BITS(INT_BITS), .FRAC_BITS(FRAC_BITS), .N_NEURONS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_idx(out_idx), .out_last(out_last),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Second instance with a non-power-of-two count so an out-of-range index is representable.
  logic          d3_in_ready, d3_out_valid, d3_out_last, d3_cfg_err, d3_busy, d3_cfg_we = 0;
  logic [W-1:0]  d3_out_y;
  logic [1:0]    d3_out_idx, d3_cfg_idx = '0, d3_dbg_state;
  neuron_layer_sched #(.INT_BITS(INT_BITS), .FRAC_BITS(FRAC_BITS), .N_NEURONS(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(1'b0), .in_ready(d3_in_ready), .in_x1('0), .in_x2('0),
    .out_valid(d3_out_valid), .out_ready(1'b1), .out_y(d3_out_y), .out_idx(d3_out_idx), .out_last(d3_out_last),
    .cfg_we(d3_cfg_we), .cfg_sel(2'd0), .cfg_idx(d3_cfg_idx), .cfg_data(18'd100), .cfg_err(d3_cfg_err),
    .busy(d3_busy), .dbg_state(d3_dbg_state)
  );

  // ---------------- reference model ----------------
  int m_w1[N], m_w2[N], m_b[N];
  int m_x1, m_x2;
  int errors = 0;
  int checks = 0;

  function automatic int to_signed(input logic [W-1:0] v);
    return (v[W-1]) ? int'(v) - (1 << W) : int'(v);
  endfunction

  // Exact sum, floor division by 2^FRAC, then W-bit reduction and ReLU.
  function automatic logic [W-1:0] ref_y(input int k);
    longint s, t, lim;
    s = longint'(m_b[k]) * (64'sd1 <<< FRAC_BITS) + longint'(m_x1) * longint'(m_w1[k])
        + longint'(m_x2) * longint'(m_w2[k]);
    t = s >>> FRAC_BITS;
    lim = (64'sd1 <<< (W - 1)) - 1;
`ifdef NEURON_SAT_EN
    if (t < 0) t = 0;
    else if (t > lim) t = lim;
`else
    t = t & ((64'sd1 <<< W) - 1);
    if (t > lim) t = 0;
`endif
    return W'(t);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [1:0] sel, input int idx, input int data);
    cfg_we = 1; cfg_sel = sel; cfg_idx = IDX_W'(idx); cfg_data = W'(data);
    @(posedge clk); #1;
    cfg_we = 0;
    if (sel == 2'd0) m_w1[idx] = to_signed(W'(data));
    else if (sel == 2'd1) m_w2[idx] = to_signed(W'(data));
    else if (sel == 2'd2) m_b[idx] = to_signed(W'(data));
  endtask

  task automatic send_pair(input int x1, input int x2);
    int n = 0;
    in_valid = 1; in_x1 = W'(x1); in_x2 = W'(x2);
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 0;
    m_x1 = to_signed(W'(x1)); m_x2 = to_signed(W'(x2));
  endtask

  task automatic get_result(input int stall, output logic [W-1:0] y, output logic [IDX_W-1:0] idx,
                            output logic last, output int lat, output logic stable, output logic tmo);
    lat = 0; tmo = 0; stable = 1; y = '0; idx = '0; last = 0;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    if (out_valid !== 1'b1) begin tmo = 1; return; end
    y = out_y; idx = out_idx; last = out_last;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_y !== y || out_idx !== idx || out_last !== last) stable = 0;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  function automatic int rnd_w();
    return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < N; i++) begin m_w1[i] = 0; m_w2[i] = 0; m_b[i] = 0; end
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0 || out_y !== '0) begin
      errors++; $display("FAIL reset_outputs valid=%b busy=%b err=%b y=%0d exp 0", out_valid, busy, cfg_err, out_y);
    end
  endtask

  task automatic test_mac_cases();
    int cw1[3] = '{4096, 4096, 131071};
    int cw2[3] = '{8192, 8192, 131071};
    int cb[3]  = '{-2048, -2048, 0};
    int cx1[3] = '{4096, -4096, 131071};
    int cx2[3] = '{2048, 2048, 131071};
    logic [W-1:0] exp0[3];
    logic [W-1:0] y; logic [IDX_W-1:0] idx; logic last, stable, tmo; int lat;
    exp0[0] = 18'd6144; exp0[1] = 18'd0;
`ifdef NEURON_SAT_EN
    exp0[2] = 18'd131071;
`else
    exp0[2] = 18'd0;
`endif
    for (int c = 0; c < 3; c++) begin
      cfg_write(2'd0, 0, cw1[c]);
      cfg_write(2'd1, 0, cw2[c]);
      cfg_write(2'd2, 0, cb[c]);
      send_pair(cx1[c], cx2[c]);
      for (int k = 0; k < N; k++) begin
        get_result(0, y, idx, last, lat, stable, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL mac%0d_timeout idx=%0d", c, k); end
        checks++; if (y !== ref_y(k) || idx !== IDX_W'(k)) begin
          errors++; $display("FAIL mac%0d_y got y=%0d idx=%0d exp y=%0d idx=%0d", c, y, idx, ref_y(k), k);
        end
        if (k == 0) begin
          checks++; if (y !== exp0[c]) begin errors++; $display("FAIL mac%0d_spec_y got=%0d exp=%0d", c, y, exp0[c]); end
          checks++; if (lat != 2) begin errors++; $display("FAIL mac%0d_latency got=%0d exp=2", c, lat); end
        end
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mac%0d_idle_after got=%b exp=1", c, in_ready); end
    end
  endtask

  task automatic test_sequencing_backpressure();
    logic [W-1:0] y; logic [IDX_W-1:0] idx; logic last, stable, tmo; int lat;
    for (int k = 0; k < N; k++) begin
      cfg_write(2'd0, k, 0); cfg_write(2'd1, k, 0); cfg_write(2'd2, k, 4096 * k);
    end
    send_pair(rnd_w(), rnd_w());
    for (int k = 0; k < N; k++) begin
      get_result((k == 1) ? 5 : 0, y, idx, last, lat, stable, tmo);
      checks++; if (tmo || y !== W'(4096 * k) || idx !== IDX_W'(k)) begin
        errors++; $display("FAIL seq_y got y=%0d idx=%0d tmo=%b exp y=%0d idx=%0d", y, idx, tmo, 4096 * k, k);
      end
      checks++; if (last !== (k == N - 1)) begin errors++; $display("FAIL seq_last idx=%0d got=%b", k, last); end
      checks++; if (!stable) begin errors++; $display("FAIL seq_stable idx=%0d got=unstable exp=stable", k); end
    end
  endtask

  task automatic test_cfg_errors();
    logic [W-1:0] y; logic [IDX_W-1:0] idx; logic last, stable, tmo; int lat;
    cfg_write(2'd0, 0, 8192); cfg_write(2'd1, 0, 0); cfg_write(2'd2, 0, 0);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_ok_no_err got=%b exp=0", cfg_err); end
    send_pair(4096, 0);
    @(posedge clk); #1;  // now in MAC2
    cfg_we = 1; cfg_sel = 2'd0; cfg_idx = '0; cfg_data = W'(300);
    @(posedge clk); #1;
    cfg_we = 0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_busy_err got=%b exp=1", cfg_err); end
    @(posedge clk); #1;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse got=%b exp=0", cfg_err); end
    for (int k = 0; k < N; k++) begin
      get_result(0, y, idx, last, lat, stable, tmo);
      checks++; if (tmo || y !== ref_y(k)) begin errors++; $display("FAIL cfg_busy_kept idx=%0d got=%0d exp=%0d", k, y, ref_y(k)); end
    end
    // Reserved register: silently ignored.
    cfg_we = 1; cfg_sel = 2'd3; cfg_idx = '0; cfg_data = W'(77);
    @(posedge clk); #1;
    cfg_we = 0;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_reserved_err got=%b exp=0", cfg_err); end
    d3_cfg_we = 1; d3_cfg_idx = 2'd3;
    @(posedge clk); #1;
    d3_cfg_we = 0;
    checks++; if (d3_cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_range_err got=%b exp=1", d3_cfg_err); end
    d3_cfg_we = 1; d3_cfg_idx = 2'd2;
    @(posedge clk); #1;
    d3_cfg_we = 0;
    checks++; if (d3_cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_range_ok got=%b exp=0", d3_cfg_err); end
  endtask

  task automatic test_cfg_same_cycle();
    logic [W-1:0] y; logic [IDX_W-1:0] idx; logic last, stable, tmo; int lat;
    cfg_write(2'd0, 0, 4096); cfg_write(2'd2, 0, 0); cfg_write(2'd1, 0, 0);
    cfg_we = 1; cfg_sel = 2'd0; cfg_idx = '0; cfg_data = W'(12288);
    m_w1[0] = 12288;
    send_pair(4096, 1000);
    cfg_we = 0;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL same_cycle_err got=%b exp=0", cfg_err); end
    for (int k = 0; k < N; k++) begin
      get_result(0, y, idx, last, lat, stable, tmo);
      checks++; if (tmo || y !== ref_y(k)) begin errors++; $display("FAIL same_cycle_y idx=%0d got=%0d exp=%0d", k, y, ref_y(k)); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] y; logic [IDX_W-1:0] idx; logic last, stable, tmo; int lat;
    for (int p = 0; p < 8; p++) begin
      for (int j = 0; j < 3; j++) cfg_write(2'($urandom_range(0, 2)), int'($urandom_range(0, N - 1)), rnd_w());
      send_pair(rnd_w(), rnd_w());
      for (int k = 0; k < N; k++) begin
        get_result(int'($urandom_range(0, 2)), y, idx, last, lat, stable, tmo);
        checks++; if (tmo || y !== ref_y(k) || idx !== IDX_W'(k) || last !== (k == N - 1) || !stable) begin
          errors++; $display("FAIL rand%0d got y=%0d idx=%0d last=%b exp y=%0d idx=%0d", p, y, idx, last, ref_y(k), k);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] y; logic [IDX_W-1:0] idx; logic last, stable, tmo; int lat;
    int n = 0;
    cfg_write(2'd2, 0, 4096); cfg_write(2'd2, 1, 8192);
    send_pair(4096, 4096);
    while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_reach_out got=%b exp=1", out_valid); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < N; i++) begin m_w1[i] = 0; m_w2[i] = 0; m_b[i] = 0; end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_state valid=%b busy=%b in_ready=%b exp 0/0/1", out_valid, busy, in_ready);
    end
    send_pair(8192, -8192);
    for (int k = 0; k < N; k++) begin
      get_result(0, y, idx, last, lat, stable, tmo);
      checks++; if (tmo || y !== ref_y(k) || y !== '0) begin errors++; $display("FAIL rst_mid_rerun idx=%0d got=%0d exp=0", k, y); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mac_cases();
    test_sequencing_backpressure();
    test_cfg_errors();
    test_cfg_same_cycle();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
